axi_wr_ctrl: RTL and testbench
==============================

AXI_WR_CTRL -- requirements
Module: axi_wr_ctrl

Interface
REQ-001 Parameter: p_size, default 4, peripheral data width is 2^p_size bytes (DW = 8<<p_size bits).
REQ-002 Parameter: ID_W, default 4, AXI ID width.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESETn  input  1  reset, asynchronous, active-low.
REQ-005 AWID/AWADDR/AWLEN/AWSIZE/AWBURST  input  ID_W/12/8/3/2  AXI write-address fields.
REQ-006 AWVALID input 1, AWREADY output 1  AW handshake.
REQ-007 WDATA/WSTRB/WLAST  input  DW/DW/8/1  AXI write-data fields.
REQ-008 WVALID input 1, WREADY output 1  W handshake.
REQ-009 BID/BRESP  output  ID_W/2  write response; BVALID output 1, BREADY input 1.
REQ-010 AG_ADDR/AG_LEN/AG_SIZE/AG_BURST  output  12/8/3/2  burst descriptor to the address generator.
REQ-011 AG_START  output  1  one-cycle load strobe to the address generator.
REQ-012 AG_NEXT  output  1  beat-advance strobe to the address generator.
REQ-013 AG_ADDR_IN  input  12  current beat address from the address generator.
REQ-014 MEM_WE/MEM_ADDR/MEM_WDATA/MEM_BE  output  1/12/DW/DW/8  synchronous memory write port.

Function
REQ-015 FSM states: IDLE, LOAD, DATA, RESP; only one burst in flight.
REQ-016 IDLE: AWREADY=1; on AWVALID&&AWREADY, register all AW fields, clear beat counter, go to LOAD.
REQ-017 AG_ADDR/LEN/SIZE/BURST driven from the registered AW fields and stable from LOAD through RESP.
REQ-018 LOAD: AG_START=1 for exactly this one cycle; next state DATA; WREADY=0.
REQ-019 DATA: WREADY=1; beat accepted when WVALID&&WREADY.
REQ-020 Per accepted beat: AG_NEXT=1 in the same cycle (combinational); beat counter (9-bit) increments.
REQ-021 Per accepted beat, if burst is good and counter<=AWLEN: MEM_WE=1, MEM_ADDR=AG_ADDR_IN, MEM_WDATA=WDATA, MEM_BE=WSTRB, all combinational in that cycle.
REQ-022 MEM_WE=0 in every other cycle; MEM_ADDR/WDATA/BE don't-care when MEM_WE=0.
REQ-023 Bad burst (decided at AW capture): AWBURST==2'b11; AWSIZE>p_size; WRAP with AWLEN not in {1,3,7,15}; INCR crossing 4KB (AWADDR + ((AWLEN+1)<<AWSIZE) > 4096, evaluated 13-bit).
REQ-024 Bad burst: all W beats still accepted, MEM_WE held 0, BRESP=2'b10 (SLVERR).
REQ-025 WLAST on beat counter==AWLEN: normal termination, go to RESP.
REQ-026 WLAST early (counter<AWLEN): go to RESP after that beat, BRESP=SLVERR; remaining beats never written.
REQ-027 No WLAST at counter==AWLEN: stay in DATA, accept and discard further beats (MEM_WE=0) until WLAST, BRESP=SLVERR.
REQ-028 RESP: BVALID=1, BID=registered AWID, BRESP=2'b00 unless an error flag set; hold all until BREADY; on BVALID&&BREADY go to IDLE.
REQ-029 AWREADY=0 in LOAD, DATA, RESP; a new AW is accepted earliest the cycle after the B handshake.
REQ-030 Minimum AW-to-first-write latency: AW handshake cycle N, LOAD N+1, first beat accepted N+2.

Reset
REQ-031 RESETn low asynchronously forces state IDLE, counter 0, error flag 0, all AW registers 0.
REQ-032 During reset outputs: AWREADY=0, WREADY=0, BVALID=0, BRESP=0, BID=0, AG_START=0, AG_NEXT=0, MEM_WE=0, AG_* fields 0.
REQ-033 AWREADY rises to 1 on the first rising edge after RESETn deasserts.
REQ-034 Reset mid-burst aborts it with no B response and no further MEM_WE.

Verification
REQ-035 INCR AWADDR=0x100, AWLEN=3, AWSIZE=4, 4 beats WLAST on 4th -> MEM_WE at 0x100,0x110,0x120,0x130 with AG_ADDR_IN fed back; BRESP=00.
REQ-036 WRAP AWADDR=0x130, AWLEN=3, AWSIZE=4 -> 4 writes, AG_START once, 4 AG_NEXT pulses; BRESP=00, BID echoes AWID.
REQ-037 AWBURST=2'b11, AWLEN=1, 2 beats -> MEM_WE never asserted; BRESP=10.
REQ-038 AWLEN=3, WLAST on beat 2 -> 2 writes, RESP after beat 2, BRESP=10; next AW accepted after B.
REQ-039 BREADY held low 5 cycles in RESP -> BVALID/BID/BRESP stable, AWREADY=0 throughout.
REQ-040 RESETn pulsed low during beat 2 of AWLEN=7 -> all outputs at reset values immediately, no BVALID, AWREADY=1 one edge after release.

Source files
------------

// File: rtl/axi_wr_ctrl.sv
// AXI4 write-channel controller: one burst in flight, drives an external address
// generator and a synchronous memory write port, and returns the B response.
module axi_wr_ctrl #(
  parameter int p_size = 4,
  parameter int ID_W   = 4,
  localparam int DW    = 8 << p_size
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic [ID_W-1:0] AWID,
  input  logic [11:0]     AWADDR,
  input  logic [7:0]      AWLEN,
  input  logic [2:0]      AWSIZE,
  input  logic [1:0]      AWBURST,
  input  logic            AWVALID,
  output logic            AWREADY,
  input  logic [DW-1:0]   WDATA,
  input  logic [DW/8-1:0] WSTRB,
  input  logic            WLAST,
  input  logic            WVALID,
  output logic            WREADY,
  output logic [ID_W-1:0] BID,
  output logic [1:0]      BRESP,
  output logic            BVALID,
  input  logic            BREADY,
  output logic [11:0]     AG_ADDR,
  output logic [7:0]      AG_LEN,
  output logic [2:0]      AG_SIZE,
  output logic [1:0]      AG_BURST,
  output logic            AG_START,
  output logic            AG_NEXT,
  input  logic [11:0]     AG_ADDR_IN,
  output logic            MEM_WE,
  output logic [11:0]     MEM_ADDR,
  output logic [DW-1:0]   MEM_WDATA,
  output logic [DW/8-1:0] MEM_BE
);

  typedef enum logic [1:0] {IDLE, LOAD, DATA, RESP} state_t;

  state_t          state_reg, state_next;
  logic            live_reg;
  logic [ID_W-1:0] aw_id_reg;
  logic [11:0]     aw_addr_reg;
  logic [7:0]      aw_len_reg;
  logic [2:0]      aw_size_reg;
  logic [1:0]      aw_burst_reg;
  logic            bad_reg;
  logic            err_reg, err_next;
  logic [8:0]      cnt_reg, cnt_next;
  logic            aw_fire;
  logic            aw_bad;
  logic [12:0]     aw_bytes;
  logic [12:0]     aw_end;

  // Burst legality is judged once, on the raw AW fields at capture time.
  always_comb begin
    aw_bytes = ({5'd0, AWLEN} + 13'd1) << AWSIZE;
    aw_end   = {1'b0, AWADDR} + aw_bytes;
    aw_bad   = 1'b0;
    if (AWBURST == 2'b11)
      aw_bad = 1'b1;
    if (int'(AWSIZE) > p_size)
      aw_bad = 1'b1;
    if (AWBURST == 2'b10 && !(AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15}))
      aw_bad = 1'b1;
    if (AWBURST == 2'b01 && aw_end > 13'd4096)
      aw_bad = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_reg    <= IDLE;
      live_reg     <= 1'b0;
      aw_id_reg    <= '0;
      aw_addr_reg  <= '0;
      aw_len_reg   <= '0;
      aw_size_reg  <= '0;
      aw_burst_reg <= '0;
      bad_reg      <= 1'b0;
      err_reg      <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg <= state_next;
      live_reg  <= 1'b1;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
      if (aw_fire) begin
        aw_id_reg    <= AWID;
        aw_addr_reg  <= AWADDR;
        aw_len_reg   <= AWLEN;
        aw_size_reg  <= AWSIZE;
        aw_burst_reg <= AWBURST;
        bad_reg      <= aw_bad;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    aw_fire    = 1'b0;
    AWREADY    = 1'b0;
    WREADY     = 1'b0;
    BVALID     = 1'b0;
    BRESP      = 2'b00;
    AG_START   = 1'b0;
    AG_NEXT    = 1'b0;
    MEM_WE     = 1'b0;
    MEM_ADDR   = AG_ADDR_IN;
    MEM_WDATA  = WDATA;
    MEM_BE     = WSTRB;
    case (state_reg)
      IDLE: begin
        // live_reg keeps AWREADY low until the first edge after reset release
        AWREADY = live_reg;
        if (AWVALID && live_reg) begin
          aw_fire    = 1'b1;
          cnt_next   = '0;
          err_next   = 1'b0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        AG_START   = 1'b1;
        state_next = DATA;
      end
      DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          AG_NEXT  = 1'b1;
          cnt_next = cnt_reg[8] ? cnt_reg : cnt_reg + 9'd1;
          MEM_WE   = !bad_reg && (cnt_reg <= {1'b0, aw_len_reg});
          if (WLAST) begin
            state_next = RESP;
            if (cnt_reg != {1'b0, aw_len_reg})
              err_next = 1'b1;
          end else if (cnt_reg >= {1'b0, aw_len_reg}) begin
            err_next = 1'b1;
          end
        end
      end
      RESP: begin
        BVALID = 1'b1;
        BRESP  = (err_reg || bad_reg) ? 2'b10 : 2'b00;
        if (BREADY)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign BID      = aw_id_reg;
  assign AG_ADDR  = aw_addr_reg;
  assign AG_LEN   = aw_len_reg;
  assign AG_SIZE  = aw_size_reg;
  assign AG_BURST = aw_burst_reg;

endmodule

// File: tb/tb_axi_wr_ctrl.sv
// Randomized + directed bench for axi_wr_ctrl with a behavioural address generator
// and a per-beat reference model of the expected memory writes and B response.
module tb_axi_wr_ctrl;
  localparam int P_SIZE = 4;
  localparam int ID_W   = 4;
  localparam int DW     = 8 << P_SIZE;
  localparam int BW     = DW / 8;

  logic            CLK = 1'b0;
  logic            RESETn = 1'b0;
  logic [ID_W-1:0] AWID = '0;
  logic [11:0]     AWADDR = '0;
  logic [7:0]      AWLEN = '0;
  logic [2:0]      AWSIZE = '0;
  logic [1:0]      AWBURST = '0;
  logic            AWVALID = 1'b0;
  logic            AWREADY;
  logic [DW-1:0]   WDATA = '0;
  logic [BW-1:0]   WSTRB = '0;
  logic            WLAST = 1'b0;
  logic            WVALID = 1'b0;
  logic            WREADY;
  logic [ID_W-1:0] BID;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY = 1'b0;
  logic [11:0]     AG_ADDR;
  logic [7:0]      AG_LEN;
  logic [2:0]      AG_SIZE;
  logic [1:0]      AG_BURST;
  logic            AG_START;
  logic            AG_NEXT;
  logic [11:0]     AG_ADDR_IN;
  logic            MEM_WE;
  logic [11:0]     MEM_ADDR;
  logic [DW-1:0]   MEM_WDATA;
  logic [BW-1:0]   MEM_BE;

  int checks = 0;
  int failures = 0;
  int ag_beat = 0;
  int start_cnt = 0;
  int next_cnt = 0;

  axi_wr_ctrl #(.p_size(P_SIZE), .ID_W(ID_W)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .AG_ADDR(AG_ADDR), .AG_LEN(AG_LEN), .AG_SIZE(AG_SIZE), .AG_BURST(AG_BURST),
    .AG_START(AG_START), .AG_NEXT(AG_NEXT), .AG_ADDR_IN(AG_ADDR_IN),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_BE(MEM_BE)
  );

  always #5 CLK = ~CLK;

  // Address of beat i of a burst, straight from the AXI burst rules.
  function automatic logic [11:0] beat_addr(input logic [11:0] a, input int len,
                                            input int size, input int burst, input int i);
    int bytes;
    int bound;
    int base;
    bytes = 1 << size;
    bound = (len + 1) * bytes;
    if (burst == 0) return a;
    if (burst == 2) begin
      base = (int'(a) / bound) * bound;
      return 12'(base + ((int'(a) - base + i * bytes) % bound));
    end
    return 12'(int'(a) + i * bytes);
  endfunction

  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) ag_beat <= 0;
    else if (AG_START) ag_beat <= 0;
    else if (AG_NEXT) ag_beat <= ag_beat + 1;
  end

  always @(posedge CLK) begin
    if (AG_START) start_cnt <= start_cnt + 1;
    if (AG_NEXT) next_cnt <= next_cnt + 1;
  end

  assign AG_ADDR_IN = beat_addr(AG_ADDR, int'(AG_LEN), int'(AG_SIZE), int'(AG_BURST), ag_beat);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"}, AWREADY, 0);
    chk({tag, "_wready"}, WREADY, 0);
    chk({tag, "_bvalid"}, BVALID, 0);
    chk({tag, "_bresp"}, BRESP, 0);
    chk({tag, "_bid"}, BID, 0);
    chk({tag, "_ag_start"}, AG_START, 0);
    chk({tag, "_ag_next"}, AG_NEXT, 0);
    chk({tag, "_mem_we"}, MEM_WE, 0);
    chk({tag, "_ag_fields"}, {AG_ADDR, AG_LEN, AG_SIZE, AG_BURST}, 0);
  endtask

  // Entered and left at a negative clock edge.
  task automatic run_burst(input logic [ID_W-1:0] id, input logic [11:0] addr, input int len,
                           input int size, input int burst, input int nbeats, input int bdelay);
    bit good;
    bit exp_err;
    int k;
    int s0;
    int n0;
    logic [1:0] exp_bresp;
    good = !(burst == 3 || size > P_SIZE || (burst == 2 && !(len inside {1, 3, 7, 15})) ||
             (burst == 1 && int'(addr) + (len + 1) * (1 << size) > 4096));
    exp_err = !good || (nbeats != len + 1);
    exp_bresp = exp_err ? 2'b10 : 2'b00;
    s0 = start_cnt;
    n0 = next_cnt;
    AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = 3'(size); AWBURST = 2'(burst);
    AWVALID = 1'b1;
    #1;
    k = 0;
    while (!AWREADY && k < 20) begin
      @(negedge CLK); #1; k++;
    end
    chk("aw_ready", AWREADY, 1);
    @(negedge CLK);
    AWVALID = 1'b0;
    #1;
    chk("load_ag_start", AG_START, 1);
    chk("load_wready", WREADY, 0);
    chk("load_awready", AWREADY, 0);
    chk("load_ag_fields", {AG_ADDR, AG_LEN, AG_SIZE, AG_BURST},
        {addr, 8'(len), 3'(size), 2'(burst)});
    @(negedge CLK);
    for (int i = 0; i < nbeats; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        WVALID = 1'b0;
        #1;
        chk("gap_wready", WREADY, 1);
        chk("gap_mem_we", MEM_WE, 0);
        chk("gap_ag_next", AG_NEXT, 0);
        @(negedge CLK);
      end
      WVALID = 1'b1;
      WDATA = {$urandom, $urandom, $urandom, $urandom};
      WSTRB = BW'($urandom);
      WLAST = (i == nbeats - 1);
      #1;
      chk("beat_wready", WREADY, 1);
      chk("beat_ag_next", AG_NEXT, 1);
      chk("beat_ag_start", AG_START, 0);
      chk("beat_mem_we", MEM_WE, good && i <= len);
      if (good && i <= len) begin
        chk("beat_mem_addr", MEM_ADDR, beat_addr(addr, len, size, burst, i));
        chk("beat_mem_wdata", MEM_WDATA, WDATA);
        chk("beat_mem_be", MEM_BE, WSTRB);
      end
      @(negedge CLK);
    end
    WVALID = 1'b0;
    WLAST = 1'b0;
    chk("ag_start_pulses", start_cnt - s0, 1);
    chk("ag_next_pulses", next_cnt - n0, nbeats);
    for (int j = 0; j < bdelay; j++) begin
      #1;
      chk("resp_bvalid_hold", BVALID, 1);
      chk("resp_bid_hold", BID, id);
      chk("resp_bresp_hold", BRESP, exp_bresp);
      chk("resp_awready_hold", AWREADY, 0);
      chk("resp_wready_hold", WREADY, 0);
      chk("resp_ag_addr_hold", AG_ADDR, addr);
      @(negedge CLK);
    end
    BREADY = 1'b1;
    #1;
    chk("resp_bvalid", BVALID, 1);
    chk("resp_bid", BID, id);
    chk("resp_bresp", BRESP, exp_bresp);
    $display("burst id=%0h addr=%03h len=%0d size=%0d type=%0d beats=%0d bresp=%0d",
             id, addr, len, size, burst, nbeats, BRESP);
    @(negedge CLK);
    BREADY = 1'b0;
    #1;
    chk("post_b_bvalid", BVALID, 0);
    chk("post_b_awready", AWREADY, 1);
    @(negedge CLK);
  endtask

  initial begin
    int lens[4];
    int sz;
    int bu;
    int ln;
    int nb;
    int mode;
    logic [11:0] ad;
    lens[0] = 1; lens[1] = 3; lens[2] = 7; lens[3] = 15;

    #1;
    check_reset_outputs("por");
    @(negedge CLK); @(negedge CLK);
    RESETn = 1'b1;
    #1;
    chk("release_awready_before_edge", AWREADY, 0);
    @(posedge CLK); #1;
    chk("release_awready_after_edge", AWREADY, 1);
    @(negedge CLK);

    run_burst(4'h5, 12'h100, 3, 4, 1, 4, 0);
    run_burst(4'h9, 12'h130, 3, 4, 2, 4, 1);
    run_burst(4'h3, 12'h040, 1, 2, 3, 2, 0);
    run_burst(4'hA, 12'h200, 3, 4, 1, 2, 0);
    run_burst(4'hB, 12'h300, 0, 3, 1, 1, 5);
    run_burst(4'hC, 12'h400, 1, 4, 1, 4, 0);
    run_burst(4'hD, 12'hFF0, 1, 4, 1, 2, 0);
    run_burst(4'h6, 12'h000, 2, 2, 2, 3, 0);
    run_burst(4'h7, 12'h010, 0, 5, 0, 1, 0);

    AWID = 4'h2; AWADDR = 12'h000; AWLEN = 8'd7; AWSIZE = 3'd4; AWBURST = 2'b01;
    AWVALID = 1'b1;
    #1;
    chk("rst_aw_ready", AWREADY, 1);
    @(negedge CLK);
    AWVALID = 1'b0;
    @(negedge CLK);
    WVALID = 1'b1; WDATA = '1; WSTRB = '1; WLAST = 1'b0;
    @(negedge CLK);
    #1;
    chk("rst_beat2_mem_we", MEM_WE, 1);
    RESETn = 1'b0;
    #1;
    check_reset_outputs("midburst");
    WVALID = 1'b0;
    @(negedge CLK); @(negedge CLK);
    RESETn = 1'b1;
    #1;
    chk("rst_awready_before_edge", AWREADY, 0);
    @(posedge CLK); #1;
    chk("rst_awready_after_edge", AWREADY, 1);
    chk("rst_no_bvalid", BVALID, 0);
    chk("rst_no_mem_we", MEM_WE, 0);
    @(negedge CLK);

    for (int n = 0; n < 25; n++) begin
      sz = $urandom_range(0, 5);
      bu = $urandom_range(0, 3);
      ln = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 20) : lens[$urandom_range(0, 3)];
      ad = 12'($urandom_range(0, 4095));
      ad = ad & 12'(~((1 << sz) - 1));
      mode = $urandom_range(0, 5);
      if (mode == 0) nb = (ln > 0) ? $urandom_range(1, ln) : 1;
      else if (mode == 1) nb = ln + 1 + $urandom_range(1, 2);
      else nb = ln + 1;
      run_burst(4'($urandom), ad, ln, sz, bu, nb, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
